// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter onto one shared memory port, one transaction outstanding
module mem_bus_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [63:0] i_addr,
    input  logic        i_flush,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_mask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,

    output logic        bus_req,
    output logic        bus_wen,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_mask,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_d;
    logic          drop;
    logic [CW-1:0] starve_cnt;
    logic          starve_full;
    logic          i_win;

    assign starve_full = (int'(starve_cnt) >= STARVE_MAX);

    // Data normally wins; a waiting fetch takes the bus once it has been passed over STARVE_MAX times.
    assign i_win = i_req && (!d_req || starve_full);

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_ready) begin
                    state_nxt = S_WAIT;
                    i_gnt     = !owner_d;
                    d_gnt     = owner_d;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_nxt = S_IDLE;
                    i_rvalid  = !owner_d && !drop && !i_flush;
                    d_rvalid  = owner_d;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign i_rdata = i_rvalid ? bus_rdata[31:0] : 32'd0;
    assign d_rdata = d_rvalid ? bus_rdata : 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            owner_d    <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= '0;
            bus_wen    <= 1'b0;
            bus_addr   <= 64'd0;
            bus_wdata  <= 64'd0;
            bus_mask   <= 8'd0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (i_win) begin
                        owner_d    <= 1'b0;
                        bus_wen    <= 1'b0;
                        bus_addr   <= i_addr;
                        bus_wdata  <= 64'd0;
                        bus_mask   <= 8'hFF;
                        starve_cnt <= '0;
                    end else if (d_req) begin
                        owner_d   <= 1'b1;
                        bus_wen   <= d_wen;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        bus_mask  <= d_mask;
                        if (!i_req) begin
                            starve_cnt <= '0;
                        end else if (!starve_full) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (!owner_d && i_flush) begin
                        drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // Clearing on completion takes precedence over a same-cycle flush.
                    if (bus_rvalid) begin
                        drop <= 1'b0;
                    end else if (!owner_d && i_flush) begin
                        drop <= 1'b1;
                    end
                end
                default: drop <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [63:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_wen, d_gnt, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_mask;
    logic        bus_req, bus_wen, bus_ready, bus_rvalid;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_mask;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_mask(bus_mask), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: the one outstanding bus transaction and its progress.
    int          m_phase;      // 0 none, 1 offered to bus, 2 accepted awaiting response
    bit          m_own_d;
    bit          m_drop;
    int          m_passed;     // data wins while a fetch was waiting
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_mask;
    bit          m_wen;
    bit          exp_ig, exp_dg;

    task automatic model_reset();
        m_phase = 0; m_own_d = 0; m_drop = 0; m_passed = 0;
        m_addr = 0; m_wdata = 0; m_mask = 0; m_wen = 0;
        exp_ig = 0; exp_dg = 0;
    endtask

    task automatic clr_inputs();
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_wen = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    task automatic eval();
        bit e_req, e_ir, e_dr;
        #1;
        e_req  = (m_phase == 1);
        exp_ig = e_req && !m_own_d && bus_ready;
        exp_dg = e_req && m_own_d && bus_ready;
        e_ir   = (m_phase == 2) && !m_own_d && bus_rvalid && !m_drop && !i_flush;
        e_dr   = (m_phase == 2) && m_own_d && bus_rvalid;
        check("bus_req", bus_req, e_req);
        check("i_gnt", i_gnt, exp_ig);
        check("d_gnt", d_gnt, exp_dg);
        check("i_rvalid", i_rvalid, e_ir);
        check("d_rvalid", d_rvalid, e_dr);
        if (e_req) begin
            check("bus_addr", bus_addr, m_addr);
            check("bus_wdata", bus_wdata, m_wdata);
            check("bus_mask", bus_mask, m_mask);
            check("bus_wen", bus_wen, m_wen);
        end
        if (e_ir) check("i_rdata", i_rdata, bus_rdata & 64'hFFFF_FFFF);
        if (e_dr) check("d_rdata", d_rdata, bus_rdata);
    endtask

    task automatic adv();
        bit take_fetch;
        @(posedge clk);
        if (m_phase == 0) begin
            if (i_req || d_req) begin
                take_fetch = i_req && (!d_req || m_passed >= STARVE_MAX);
                if (take_fetch) begin
                    m_own_d = 0; m_addr = i_addr; m_wdata = 0; m_mask = 8'hFF; m_wen = 0;
                    m_passed = 0;
                end else begin
                    m_own_d = 1; m_addr = d_addr; m_wdata = d_wdata; m_mask = d_mask; m_wen = d_wen;
                    m_passed = i_req ? ((m_passed < STARVE_MAX) ? m_passed + 1 : STARVE_MAX) : 0;
                end
                m_phase = 1;
            end else begin
                m_passed = 0;
            end
        end else begin
            if (!m_own_d && i_flush) m_drop = 1;
            if (m_phase == 1 && bus_ready) m_phase = 2;
            else if (m_phase == 2 && bus_rvalid) begin
                m_phase = 0;
                m_drop  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_inputs();
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_mask", bus_mask, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_gnt", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        rst = 0;
    endtask

    int  dg;
    bit  seen_i, resumed, i_pend, d_pend;

    initial begin
        do_reset();

        // Single fetch, minimum latency.
        i_req = 1; i_addr = 64'h8000_0000; bus_ready = 1; bus_rdata = 64'h513;
        eval(); check("t040_no_gnt_in_idle", i_gnt, 0); adv();
        eval(); check("t040_i_gnt", i_gnt, 1); check("t040_mask", bus_mask, 8'hFF);
        check("t040_wen", bus_wen, 0); adv();
        i_req = 0; bus_rvalid = 1;
        eval(); check("t040_i_rvalid", i_rvalid, 1); check("t040_i_rdata", i_rdata, 32'h513); adv();
        bus_rvalid = 0;
        eval(); check("t040_back_idle", bus_req, 0); adv();

        // Simultaneous requests: store served first.
        i_req = 1; i_addr = 64'h8000_0004;
        d_req = 1; d_wen = 1; d_addr = 64'h8000_1000; d_wdata = 64'h1234; d_mask = 8'h0F;
        eval(); adv();
        eval(); check("t041_d_gnt", d_gnt, 1); check("t041_wen", bus_wen, 1);
        check("t041_mask", bus_mask, 8'h0F); check("t041_no_i_gnt", i_gnt, 0); adv();
        d_req = 0; bus_rvalid = 1;
        eval(); check("t041_d_rvalid", d_rvalid, 1); adv();
        bus_rvalid = 0;
        eval(); adv();
        eval(); check("t041_i_gnt_after", i_gnt, 1); check("t041_i_addr", bus_addr, 64'h8000_0004); adv();
        i_req = 0; bus_rvalid = 1;
        eval(); adv();
        bus_rvalid = 0;

        // Bus stall: fields held steady until accepted.
        d_req = 1; d_wen = 0; d_addr = 64'hDEAD_BEE0; d_mask = 8'hF0; bus_ready = 0;
        eval(); adv();
        for (int k = 0; k < 5; k++) begin
            eval();
            check("t044_req_held", bus_req, 1);
            check("t044_addr_held", bus_addr, 64'hDEAD_BEE0);
            check("t044_no_gnt", d_gnt, 0);
            adv();
        end
        bus_ready = 1;
        eval(); check("t044_gnt", d_gnt, 1); adv();
        d_req = 0; bus_rvalid = 1;
        eval(); adv();
        bus_rvalid = 0;

        // Flush during WAIT suppresses the fetch response only.
        i_req = 1; i_addr = 64'h8000_0100;
        eval(); adv();
        eval(); adv();
        i_req = 0; i_flush = 1;
        eval(); adv();
        i_flush = 0; bus_rvalid = 1; bus_rdata = 64'h1111;
        eval(); check("t043_dropped", i_rvalid, 0); adv();
        bus_rvalid = 0; i_req = 1; i_addr = 64'h8000_0200;
        eval(); adv();
        eval(); check("t043_next_gnt", i_gnt, 1); adv();
        i_req = 0; bus_rvalid = 1;
        eval(); check("t043_next_rvalid", i_rvalid, 1); adv();
        bus_rvalid = 0;

        // Starvation bound with data held continuously.
        do_reset();
        i_req = 1; i_addr = 64'h8000_0300; d_req = 1; d_addr = 64'h9000_0000;
        bus_ready = 1; bus_rvalid = 1;
        dg = 0; seen_i = 0; resumed = 0;
        for (int c = 0; c < 80 && !resumed; c++) begin
            eval();
            if (d_gnt && seen_i) resumed = 1;
            if (d_gnt && !seen_i) dg++;
            if (i_gnt) seen_i = 1;
            adv();
            if (seen_i) i_req = 0;
        end
        check("t042_data_grants", dg, STARVE_MAX);
        check("t042_fetch_granted", seen_i, 1);
        check("t042_data_resumed", resumed, 1);
        d_req = 0;
        eval(); adv();
        bus_rvalid = 0;

        // Asynchronous reset in WAIT, then a stale response.
        i_req = 1; i_addr = 64'h8000_0400;
        eval(); adv();
        eval(); adv();
        i_req = 0;
        #2 rst = 1;
        #1;
        check("t045_bus_req", bus_req, 0);
        check("t045_bus_addr", bus_addr, 0);
        check("t045_bus_wdata", bus_wdata, 0);
        check("t045_bus_mask", bus_mask, 0);
        check("t045_bus_wen", bus_wen, 0);
        check("t045_handshakes", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        model_reset();
        @(negedge clk);
        rst = 0; bus_rvalid = 1;
        eval(); check("t045_stale_rvalid", i_rvalid, 0); adv();
        bus_rvalid = 0;

        // Randomized traffic against the reference.
        i_pend = 0; d_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = {$urandom, $urandom};
            end
            if (!d_pend && $urandom_range(0, 1) == 0) begin
                d_pend = 1; d_wen = 1'($urandom); d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom}; d_mask = 8'($urandom);
            end
            i_req      = i_pend;
            d_req      = d_pend;
            bus_ready  = ($urandom_range(0, 2) != 0);
            bus_rvalid = 1'($urandom);
            bus_rdata  = {$urandom, $urandom};
            i_flush    = ($urandom_range(0, 9) == 0);
            eval();
            if (exp_ig) i_pend = 0;
            if (exp_dg) d_pend = 0;
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
